// File: rtl/micro_udp_engine_eth_rx.sv
// Ethernet RX de-framer: filters on destination MAC, dispatches ARP/IPv4 by ethertype,
// strips the 14-byte header and re-aligns the payload to byte 0 of beat 0.
module micro_udp_engine_eth_rx #(
  parameter logic [47:0] CONFIG_MAC_ADDR = 48'h0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] l4_rx_data,
  input  logic [4:0]   l4_rx_empty,
  input  logic         l4_rx_startofpacket,
  input  logic         l4_rx_endofpacket,
  input  logic         l4_rx_valid,
  output logic         l4_rx_ready,
  output logic [255:0] arp_rx_data,
  output logic [4:0]   arp_rx_empty,
  output logic         arp_rx_startofpacket,
  output logic         arp_rx_endofpacket,
  output logic         arp_rx_valid,
  input  logic         arp_rx_ready,
  output logic [255:0] ipv4_rx_data,
  output logic [4:0]   ipv4_rx_empty,
  output logic         ipv4_rx_startofpacket,
  output logic         ipv4_rx_endofpacket,
  output logic         ipv4_rx_valid,
  input  logic         ipv4_rx_ready,
  output logic [47:0]  rx_src_mac,
  output logic [31:0]  stat_arp_frames,
  output logic [31:0]  stat_ipv4_frames,
  output logic [31:0]  stat_dropped_frames
);

  localparam logic [15:0] ETH_ARP   = 16'h0806;
  localparam logic [15:0] ETH_IPV4  = 16'h0800;
  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [4:0]  HDR_SPILL = 5'd18;

  typedef enum logic [1:0] {S_IDLE, S_DROP, S_FWD, S_TAIL} state_t;

  state_t        state_q, state_d;
  logic          sel_arp_q, sel_arp_d;
  logic          first_out_q, first_out_d;
  logic [143:0]  prev_data_q, prev_data_d;
  logic [4:0]    prev_empty_q, prev_empty_d;
  logic [47:0]   src_mac_q, src_mac_d;
  logic [31:0]   arp_cnt_q, arp_cnt_d;
  logic [31:0]   ipv4_cnt_q, ipv4_cnt_d;
  logic [31:0]   drop_cnt_q, drop_cnt_d;

  logic          rdy_c;
  logic          sel_ready;
  logic          out_valid;
  logic [255:0]  out_data;
  logic [4:0]    out_empty;
  logic          out_sop;
  logic          out_eop;
  logic [47:0]   hdr_dest;
  logic [15:0]   hdr_type;
  logic          dest_ok;
  logic          fits_one;

  assign hdr_dest  = l4_rx_data[255:208];
  assign hdr_type  = l4_rx_data[159:144];
  assign dest_ok   = (hdr_dest == CONFIG_MAC_ADDR) || (hdr_dest == MAC_BCAST);
  // Last beat with at most 14 valid bytes folds entirely into the current output beat.
  assign fits_one  = (l4_rx_empty >= HDR_SPILL);
  assign sel_ready = sel_arp_q ? arp_rx_ready : ipv4_rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sel_arp_q    <= 1'b0;
      first_out_q  <= 1'b0;
      prev_data_q  <= '0;
      prev_empty_q <= '0;
      src_mac_q    <= '0;
      arp_cnt_q    <= '0;
      ipv4_cnt_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      sel_arp_q    <= sel_arp_d;
      first_out_q  <= first_out_d;
      prev_data_q  <= prev_data_d;
      prev_empty_q <= prev_empty_d;
      src_mac_q    <= src_mac_d;
      arp_cnt_q    <= arp_cnt_d;
      ipv4_cnt_q   <= ipv4_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_arp_d    = sel_arp_q;
    first_out_d  = first_out_q;
    prev_data_d  = prev_data_q;
    prev_empty_d = prev_empty_q;
    src_mac_d    = src_mac_q;
    arp_cnt_d    = arp_cnt_q;
    ipv4_cnt_d   = ipv4_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    rdy_c        = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_empty    = '0;
    out_sop      = 1'b0;
    out_eop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        rdy_c = 1'b1;
        if (l4_rx_valid && l4_rx_startofpacket) begin
          src_mac_d    = l4_rx_data[207:160];
          prev_data_d  = l4_rx_data[143:0];
          prev_empty_d = l4_rx_empty;
          if (l4_rx_endofpacket) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
          end else if (!dest_ok) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
            state_d    = S_DROP;
          end else if (hdr_type == ETH_ARP) begin
            sel_arp_d   = 1'b1;
            arp_cnt_d   = arp_cnt_q + 32'd1;
            first_out_d = 1'b1;
            state_d     = S_FWD;
          end else if (hdr_type == ETH_IPV4) begin
            sel_arp_d   = 1'b0;
            ipv4_cnt_d  = ipv4_cnt_q + 32'd1;
            first_out_d = 1'b1;
            state_d     = S_FWD;
          end else begin
            drop_cnt_d = drop_cnt_q + 32'd1;
            state_d    = S_DROP;
          end
        end
      end

      S_DROP: begin
        rdy_c = 1'b1;
        if (l4_rx_valid && l4_rx_endofpacket) state_d = S_IDLE;
      end

      S_FWD: begin
        rdy_c     = sel_ready;
        out_valid = l4_rx_valid;
        out_data  = {prev_data_q, l4_rx_data[255:144]};
        out_sop   = first_out_q;
        if (l4_rx_endofpacket && fits_one) begin
          out_eop   = 1'b1;
          out_empty = l4_rx_empty - HDR_SPILL;
        end
        if (l4_rx_valid && sel_ready) begin
          prev_data_d  = l4_rx_data[143:0];
          prev_empty_d = l4_rx_empty;
          first_out_d  = 1'b0;
          if (l4_rx_endofpacket) state_d = fits_one ? S_IDLE : S_TAIL;
        end
      end

      S_TAIL: begin
        out_valid = 1'b1;
        out_data  = {prev_data_q, 112'd0};
        out_eop   = 1'b1;
        out_empty = prev_empty_q + 5'd14;
        if (sel_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign l4_rx_ready           = rdy_c && !reset;

  assign arp_rx_data           = out_data;
  assign arp_rx_empty          = out_empty;
  assign arp_rx_startofpacket  = out_sop;
  assign arp_rx_endofpacket    = out_eop;
  assign arp_rx_valid          = out_valid && sel_arp_q;

  assign ipv4_rx_data          = out_data;
  assign ipv4_rx_empty         = out_empty;
  assign ipv4_rx_startofpacket = out_sop;
  assign ipv4_rx_endofpacket   = out_eop;
  assign ipv4_rx_valid         = out_valid && !sel_arp_q;

  assign rx_src_mac            = src_mac_q;
  assign stat_arp_frames       = arp_cnt_q;
  assign stat_ipv4_frames      = ipv4_cnt_q;
  assign stat_dropped_frames   = drop_cnt_q;

endmodule

// File: tb/tb_micro_udp_engine_eth_rx.sv
// Randomized bench for the Ethernet RX de-framer; frames are byte lists and the model
// derives expected payload beats from frame bytes directly.
module tb_micro_udp_engine_eth_rx;

  localparam logic [47:0] OWN_MAC = 48'h02_00_00_00_00_01;

  typedef byte unsigned bq_t[$];
  typedef struct {
    logic [255:0] data;
    logic [4:0]   empty;
    logic         sop;
    logic         eop;
    logic         arp;
    logic [47:0]  src;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] l4_rx_data = '0;
  logic [4:0]   l4_rx_empty = '0;
  logic         l4_rx_startofpacket = 1'b0;
  logic         l4_rx_endofpacket = 1'b0;
  logic         l4_rx_valid = 1'b0;
  logic         l4_rx_ready;
  logic [255:0] arp_rx_data, ipv4_rx_data;
  logic [4:0]   arp_rx_empty, ipv4_rx_empty;
  logic         arp_rx_startofpacket, arp_rx_endofpacket, arp_rx_valid;
  logic         ipv4_rx_startofpacket, ipv4_rx_endofpacket, ipv4_rx_valid;
  logic         arp_rx_ready = 1'b1;
  logic         ipv4_rx_ready = 1'b1;
  logic [47:0]  rx_src_mac;
  logic [31:0]  stat_arp_frames, stat_ipv4_frames, stat_dropped_frames;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   m_arp = 0, m_ipv4 = 0, m_drop = 0;
  bit   rnd_bp = 1'b0;
  bit   stall_arp = 1'b0;
  int   gap_max = 0;

  micro_udp_engine_eth_rx #(.CONFIG_MAC_ADDR(OWN_MAC)) dut (
    .clk(clk), .reset(reset),
    .l4_rx_data(l4_rx_data), .l4_rx_empty(l4_rx_empty),
    .l4_rx_startofpacket(l4_rx_startofpacket), .l4_rx_endofpacket(l4_rx_endofpacket),
    .l4_rx_valid(l4_rx_valid), .l4_rx_ready(l4_rx_ready),
    .arp_rx_data(arp_rx_data), .arp_rx_empty(arp_rx_empty),
    .arp_rx_startofpacket(arp_rx_startofpacket), .arp_rx_endofpacket(arp_rx_endofpacket),
    .arp_rx_valid(arp_rx_valid), .arp_rx_ready(arp_rx_ready),
    .ipv4_rx_data(ipv4_rx_data), .ipv4_rx_empty(ipv4_rx_empty),
    .ipv4_rx_startofpacket(ipv4_rx_startofpacket), .ipv4_rx_endofpacket(ipv4_rx_endofpacket),
    .ipv4_rx_valid(ipv4_rx_valid), .ipv4_rx_ready(ipv4_rx_ready),
    .rx_src_mac(rx_src_mac), .stat_arp_frames(stat_arp_frames),
    .stat_ipv4_frames(stat_ipv4_frames), .stat_dropped_frames(stat_dropped_frames)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Sink ready driver; updated just after each edge, after the input driver.
  initial forever begin
    @(posedge clk); #2;
    arp_rx_ready  = !stall_arp && (rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
    ipv4_rx_ready = rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Output monitor: every sink handshake is checked against the model queue.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (arp_rx_valid && ipv4_rx_valid) chk("both_valid", 1, 0);
      if ((arp_rx_valid && arp_rx_ready) || (ipv4_rx_valid && ipv4_rx_ready)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sink_arp", arp_rx_valid, e.arp);
          chk("out_data", arp_rx_data, e.data);
          chk("bus_shared", ipv4_rx_data, e.data);
          chk("out_empty", arp_rx_empty, e.empty);
          chk("out_sop", arp_rx_startofpacket, e.sop);
          chk("out_eop", arp_rx_endofpacket, e.eop);
          chk("src_mac", rx_src_mac, e.src);
        end
      end
    end
  end

  task automatic make_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input int len, output bq_t fr);
    fr = {};
    for (int i = 0; i < 6; i++) fr.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(s[47-8*i -: 8]);
    fr.push_back(t[15:8]);
    fr.push_back(t[7:0]);
    while (fr.size() < len) fr.push_back(8'($urandom));
  endtask

  // Reference: classify frame, then chop bytes 14.. into 32-byte output beats.
  task automatic model_push(input bq_t fr);
    logic [47:0] d, s;
    logic [15:0] t;
    int p, nb;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      d[47-8*i -: 8] = fr[i];
      s[47-8*i -: 8] = fr[6+i];
    end
    t = {fr[12], fr[13]};
    if (fr.size() <= 32 || !(d == OWN_MAC || d == 48'hFFFF_FFFF_FFFF) ||
        !(t == 16'h0806 || t == 16'h0800)) begin
      m_drop++;
      return;
    end
    if (t == 16'h0806) m_arp++; else m_ipv4++;
    p  = fr.size() - 14;
    nb = (p + 31) / 32;
    for (int k = 0; k < nb; k++) begin
      e.data = '0;
      for (int j = 0; j < 32; j++)
        if (32*k + j < p) e.data[255-8*j -: 8] = fr[14 + 32*k + j];
      e.sop   = (k == 0);
      e.eop   = (k == nb - 1);
      e.empty = e.eop ? 5'(32*nb - p) : 5'd0;
      e.arp   = (t == 16'h0806);
      e.src   = s;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_beat(input bq_t fr, input int b);
    int nb, t;
    bit acc;
    nb = (fr.size() + 31) / 32;
    repeat ($urandom_range(0, gap_max)) begin
      l4_rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    l4_rx_data = '0;
    for (int j = 0; j < 32; j++)
      if (32*b + j < fr.size()) l4_rx_data[255-8*j -: 8] = fr[32*b + j];
    l4_rx_startofpacket = (b == 0);
    l4_rx_endofpacket   = (b == nb - 1);
    l4_rx_empty         = (b == nb - 1) ? 5'(32*nb - fr.size()) : 5'd0;
    l4_rx_valid         = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      acc = l4_rx_ready;
      @(posedge clk); #1;
      t++;
    end while (!acc && t < 500);
    if (!acc) chk("l4_accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input bq_t fr);
    model_push(fr);
    for (int b = 0; b < (fr.size() + 31) / 32; b++) drive_beat(fr, b);
    l4_rx_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_arp"},  stat_arp_frames,     m_arp);
    chk({tag, "_ipv4"}, stat_ipv4_frames,    m_ipv4);
    chk({tag, "_drop"}, stat_dropped_frames, m_drop);
  endtask

  initial begin
    bq_t fr;
    logic [47:0] s, d;
    logic [15:0] ty;
    int len;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_l4_ready", l4_rx_ready, 0);
    chk("rst_arp_valid", arp_rx_valid, 0);
    chk("rst_ipv4_valid", ipv4_rx_valid, 0);
    chk("rst_empty", arp_rx_empty, 0);
    chk("rst_src", rx_src_mac, 0);
    check_stats("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset after the header beat of an IPv4 frame; remaining beats must vanish.
    make_frame(OWN_MAC, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 100, fr);
    drive_beat(fr, 0);
    l4_rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_l4_ready", l4_rx_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int b = 1; b < 4; b++) drive_beat(fr, b);
    l4_rx_valid = 1'b0;
    drain();
    check_stats("midrst");

    // ARP broadcast 60B -> sop beat then tail with empty 18.
    make_frame(48'hFFFF_FFFF_FFFF, 48'h00_11_22_33_44_55, 16'h0806, 60, fr);
    send_frame(fr);
    drain();
    check_stats("arp60");

    // IPv4 own MAC 64B -> tail empty 14.
    make_frame(OWN_MAC, 48'h66_77_88_99_AA_BB, 16'h0800, 64, fr);
    send_frame(fr);
    drain();
    chk("ipv4_src_held", rx_src_mac, 48'h66_77_88_99_AA_BB);
    check_stats("ipv4_64");

    // 46B -> one sop&eop beat, empty 0, no tail.
    make_frame(OWN_MAC, 48'h12_34_56_78_9A_BC, 16'h0800, 46, fr);
    send_frame(fr);
    drain();

    // Foreign dest, then unknown ethertype: both dropped.
    make_frame(48'h02_00_00_00_00_99, 48'h1, 16'h0800, 80, fr);
    send_frame(fr);
    make_frame(OWN_MAC, 48'h2, 16'h86DD, 80, fr);
    send_frame(fr);
    drain();
    check_stats("drops");
    chk("drops_total", stat_dropped_frames, 2);

    // ARP 60B with the ARP sink stalled for three cycles during the tail.
    make_frame(48'hFFFF_FFFF_FFFF, 48'hDE_AD_BE_EF_00_01, 16'h0806, 60, fr);
    model_push(fr);
    drive_beat(fr, 0);
    drive_beat(fr, 1);
    l4_rx_valid = 1'b0;
    stall_arp = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("tail_l4_ready", l4_rx_ready, 0);
      chk("tail_valid", arp_rx_valid, 1);
      chk("tail_data", arp_rx_data, (exp_q.size() != 0) ? exp_q[0].data : 256'd0);
      chk("tail_empty", arp_rx_empty, 18);
    end
    @(posedge clk); #1;
    stall_arp = 1'b0;
    drain();
    check_stats("tail_stall");

    // Randomized traffic with backpressure and input gaps.
    rnd_bp  = 1'b1;
    gap_max = 2;
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 9))
        0:       len = 32;
        1:       len = 33;
        2:       len = 46;
        3:       len = 47;
        4:       len = $urandom_range(14, 31);
        default: len = $urandom_range(33, 200);
      endcase
      case ($urandom_range(0, 5))
        0, 1:    d = OWN_MAC;
        2, 3:    d = 48'hFFFF_FFFF_FFFF;
        4:       d = OWN_MAC ^ 48'h1;
        default: d = {16'($urandom), 32'($urandom)};
      endcase
      case ($urandom_range(0, 5))
        0, 1:    ty = 16'h0806;
        2, 3:    ty = 16'h0800;
        4:       ty = 16'h8100;
        default: ty = 16'($urandom);
      endcase
      s = {16'($urandom), 32'($urandom)};
      make_frame(d, s, ty, len, fr);
      send_frame(fr);
    end
    drain();
    check_stats("random");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
